// File: rtl/c_fetch_buffer_pkg.sv
// Shared compressed-extension definitions for the fetch front end.
//   PARCEL_W      : width of one instruction halfword parcel
//   C_OPCODE_32   : low two bits that mark a parcel as the first half of a
//                   32-bit instruction (anything else is compressed)
//   type_parcel_s : one buffered parcel together with its own address
package c_fetch_buffer_pkg;

  localparam int         PARCEL_W    = 16;
  localparam logic [1:0] C_OPCODE_32 = 2'b11;

  typedef struct packed {
    logic [PARCEL_W-1:0] data;
    logic [31:0]         pc;
  } type_parcel_s;

endpackage

// File: rtl/c_parcel_ram.sv
// Parcel storage for the fetch buffer: DEPTH x {parcel, pc} register array.
//   clk            : core clock
//   we0/waddr0/wdata0, we1/waddr1/wdata1 : two independent write ports
//   raddr0/rdata0, raddr1/rdata1         : two combinational read ports
// Contents are data only and carry no reset; validity is tracked by the
// owner through its pointers and count.
module c_parcel_ram
  import c_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we0,
  input  logic [PTR_W-1:0] waddr0,
  input  type_parcel_s     wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] waddr1,
  input  type_parcel_s     wdata1,
  input  logic [PTR_W-1:0] raddr0,
  output type_parcel_s     rdata0,
  input  logic [PTR_W-1:0] raddr1,
  output type_parcel_s     rdata1
);

  type_parcel_s mem [DEPTH];

  // The owner never targets the same entry from both ports in one cycle
  // (they always address consecutive slots), so write order is irrelevant.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/c_fetch_buffer.sv
// Halfword-parcel FIFO between the icache response and the compressed
// misalign/decode stage. Aligned 32-bit fetch words are split into two
// 16-bit parcels; the head presents one whole instruction per beat
// (compressed, or 32-bit possibly straddling two fetch words).
//   clk, reset          : core clock, synchronous active-high reset
//   flush_i, flush_pc_i : redirect; empties the buffer, flush_pc_i[1]
//                         marks the lower parcel of the next word as dead
//   in_valid_i/in_ready_o, in_pc_i, in_word_i : fetch word input
//   out_valid_o/out_ready_i, out_instr_o, out_is_comp_o, out_pc_o :
//                         instruction output, zeroed when not valid
module c_fetch_buffer
  import c_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_pc_i,
  input  logic [31:0] in_word_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic        out_is_comp_o,
  output logic [31:0] out_pc_o
);

  localparam logic [PTR_W:0] ROOM_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  function automatic logic parcel_is_comp(input logic [PARCEL_W-1:0] parcel);
    return parcel[1:0] != C_OPCODE_32;
  endfunction

  function automatic logic [31:0] join_instr(input logic                comp,
                                             input logic [PARCEL_W-1:0] lo,
                                             input logic [PARCEL_W-1:0] hi);
    return comp ? {16'h0000, lo} : {hi, lo};
  endfunction

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             drop_low;

  type_parcel_s     head_p0;
  type_parcel_s     head_p1;
  type_parcel_s     wdata0;
  type_parcel_s     wdata1;

  logic             head_comp;
  logic             head_vld;
  logic             push;
  logic             pop;
  logic [PTR_W:0]   push_n;
  logic [PTR_W:0]   pop_n;

  // ---- handshake decode ----
  assign in_ready_o = (count <= ROOM_MAX) && !flush_i;
  assign push       = in_valid_i && in_ready_o;

  assign head_comp  = parcel_is_comp(head_p0.data);
  // A 32-bit head with only its lower half buffered waits for the next word.
  assign head_vld   = (count >= CNT_ONE && head_comp) ||
                      (count >= CNT_TWO && !head_comp);
  assign pop        = head_vld && out_ready_i && !flush_i;

  assign push_n = !push ? '0 : (drop_low ? CNT_ONE : CNT_TWO);
  assign pop_n  = !pop  ? '0 : (head_comp ? CNT_ONE : CNT_TWO);

  // After a redirect to an odd halfword only the upper parcel is useful; it
  // then lands in the slot the lower parcel would normally have taken.
  always_comb begin
    wdata0 = '{data: in_word_i[15:0], pc: in_pc_i};
    if (drop_low) wdata0 = '{data: in_word_i[31:16], pc: in_pc_i + 32'd2};
    wdata1 = '{data: in_word_i[31:16], pc: in_pc_i + 32'd2};
  end

  // ---- storage ----
  c_parcel_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk    (clk),
    .we0    (push),
    .waddr0 (wr_ptr),
    .wdata0 (wdata0),
    .we1    (push && !drop_low),
    .waddr1 (wr_ptr + PTR_W'(1)),
    .wdata1 (wdata1),
    .raddr0 (rd_ptr),
    .rdata0 (head_p0),
    .raddr1 (rd_ptr + PTR_W'(1)),
    .rdata1 (head_p1)
  );

  // ---- control state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_low <= 1'b0;
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_low <= flush_pc_i[1];
    end else begin
      rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
      wr_ptr <= wr_ptr + push_n[PTR_W-1:0];
      count  <= count + push_n - pop_n;
      if (push) drop_low <= 1'b0;
    end
  end

  // ---- output head ----
  always_comb begin
    out_valid_o   = head_vld;
    out_instr_o   = '0;
    out_is_comp_o = 1'b0;
    out_pc_o      = '0;
    if (head_vld) begin
      out_instr_o   = join_instr(head_comp, head_p0.data, head_p1.data);
      out_is_comp_o = head_comp;
      out_pc_o      = head_p0.pc;
    end
  end

  // The upper parcel's address is implied by the head address.
  logic unused_ok;
  assign unused_ok = ^{head_p1.pc, flush_pc_i[31:2], flush_pc_i[0]};

  // Structural guarantees of the pointer/count bookkeeping.
  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    count <= FULL_CNT);
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
    pop |-> (count != '0));

endmodule

// File: tb/tb_c_fetch_buffer.sv
module tb_c_fetch_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_pc_i;
  logic [31:0] in_word_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic        out_is_comp_o;
  logic [31:0] out_pc_o;

  c_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_pc_i       (in_pc_i),
    .in_word_i     (in_word_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .out_is_comp_o (out_is_comp_o),
    .out_pc_o      (out_pc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: an ordered list of live parcels plus the pending
  // "skip the low halfword" flag left by a redirect.
  typedef struct {
    logic [15:0] d;
    logic [31:0] pc;
  } parcel_t;

  parcel_t mq[$];
  bit      m_drop = 1'b0;

  function automatic bit m_comp();
    return (mq.size() > 0) && (mq[0].d[1:0] != 2'b11);
  endfunction

  function automatic bit m_valid();
    return (mq.size() >= 1) && (m_comp() || mq.size() >= 2);
  endfunction

  function automatic bit m_ready();
    return (mq.size() <= DEPTH - 2) && !flush_i;
  endfunction

  task automatic model_check();
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_comp;
    e_instr = 32'h0;
    e_pc    = 32'h0;
    e_comp  = 1'b0;
    if (m_valid()) begin
      e_comp  = m_comp();
      e_pc    = mq[0].pc;
      e_instr = e_comp ? {16'h0, mq[0].d} : {mq[1].d, mq[0].d};
    end
    check_val("in_ready",  {31'h0, in_ready_o},    {31'h0, m_ready()});
    check_val("out_valid", {31'h0, out_valid_o},   {31'h0, m_valid()});
    check_val("is_comp",   {31'h0, out_is_comp_o}, {31'h0, e_comp});
    check_val("instr",     out_instr_o,            e_instr);
    check_val("pc",        out_pc_o,               e_pc);
  endtask

  task automatic model_update();
    bit v, c, r;
    parcel_t p;
    v = m_valid();
    c = m_comp();
    r = m_ready();
    if (reset) begin
      mq.delete();
      m_drop = 1'b0;
    end else if (flush_i) begin
      mq.delete();
      m_drop = flush_pc_i[1];
    end else begin
      if (v && out_ready_i) begin
        void'(mq.pop_front());
        if (!c) void'(mq.pop_front());
      end
      if (in_valid_i && r) begin
        if (!m_drop) begin
          p.d = in_word_i[15:0];  p.pc = in_pc_i;
          mq.push_back(p);
        end
        p.d = in_word_i[31:16]; p.pc = in_pc_i + 32'd2;
        mq.push_back(p);
        m_drop = 1'b0;
      end
    end
  endtask

  // Drive one cycle's inputs away from the active edge and compare the
  // settled outputs against the model.
  task automatic apply(input logic rst, input logic fl, input logic [31:0] flpc,
                       input logic iv, input logic [31:0] ipc,
                       input logic [31:0] iw, input logic ordy);
    @(negedge clk);
    reset = rst; flush_i = fl; flush_pc_i = flpc;
    in_valid_i = iv; in_pc_i = ipc; in_word_i = iw; out_ready_i = ordy;
    #1;
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
  endtask

  task automatic expect_head(input string tag, input logic v, input logic c,
                             input logic [31:0] instr, input logic [31:0] pc);
    check_val({tag, "_valid"}, {31'h0, out_valid_o},   {31'h0, v});
    check_val({tag, "_comp"},  {31'h0, out_is_comp_o}, {31'h0, c});
    check_val({tag, "_instr"}, out_instr_o, instr);
    check_val({tag, "_pc"},    out_pc_o,    pc);
  endtask

  function automatic logic [15:0] rand_parcel();
    logic [15:0] p;
    p = 16'($urandom());
    if ($urandom_range(1, 0) == 1) p[1:0] = 2'b11;
    return p;
  endfunction

  initial begin
    reset = 1'b1; flush_i = 1'b0; flush_pc_i = '0; in_valid_i = 1'b0;
    in_pc_i = '0; in_word_i = '0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    apply(0, 0, 0, 0, 0, 0, 0);
    expect_head("rst", 0, 0, 32'h0, 32'h0);
    check_val("rst_in_ready", {31'h0, in_ready_o}, 32'h1);
    tick();

    // Two compressed parcels
    apply(0, 0, 0, 1, 32'h100, 32'h0001_0001, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("c0", 1, 1, 32'h1, 32'h100); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("c1", 1, 1, 32'h1, 32'h102); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    expect_head("c_empty", 0, 0, 32'h0, 32'h0); tick();

    // One aligned 32-bit instruction
    apply(0, 0, 0, 1, 32'h200, 32'h0013_0513, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("w32", 1, 0, 32'h0013_0513, 32'h200); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    expect_head("w32_empty", 0, 0, 32'h0, 32'h0); tick();

    // Straddling 32-bit instruction
    apply(0, 0, 0, 1, 32'h300, 32'h0513_0001, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("st_c", 1, 1, 32'h1, 32'h300); tick();
    apply(0, 0, 0, 1, 32'h304, 32'h0001_0013, 0);
    expect_head("st_half", 0, 0, 32'h0, 32'h0); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("st_full", 1, 0, 32'h0013_0513, 32'h302); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("st_tail", 1, 1, 32'h1, 32'h306); tick();

    // Redirect to an odd halfword
    apply(0, 1, 32'h402, 0, 0, 0, 0);
    check_val("fl_in_ready", {31'h0, in_ready_o}, 32'h0); tick();
    apply(0, 0, 0, 1, 32'h400, 32'h0001_0513, 0); tick();
    apply(0, 0, 0, 0, 0, 0, 1);
    expect_head("odd", 1, 1, 32'h1, 32'h402); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    expect_head("odd_empty", 0, 0, 32'h0, 32'h0); tick();

    // Fill to full with the consumer stalled, then drain while pushing
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1, 32'h500 + 32'(4 * i), 32'h0513_0001 + 32'(i), 0);
      check_val("fill_ready", {31'h0, in_ready_o}, 32'h1); tick();
    end
    apply(0, 0, 0, 1, 32'h510, 32'h0001_0001, 0);
    check_val("full_ready", {31'h0, in_ready_o}, 32'h0); tick();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 1, 32'h600 + 32'(4 * i), {rand_parcel(), rand_parcel()}, 1);
      tick();
    end

    // Flush colliding with both handshakes
    apply(0, 1, 32'h0, 1, 32'h700, 32'h0001_0001, 1);
    check_val("flc_in_ready", {31'h0, in_ready_o}, 32'h0); tick();
    apply(0, 0, 0, 0, 0, 0, 0);
    expect_head("flc_after", 0, 0, 32'h0, 32'h0);
    check_val("flc_after_ready", {31'h0, in_ready_o}, 32'h1); tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(199, 0) == 0),
            ($urandom_range(19, 0) == 0),
            $urandom() & 32'hFFFF_FFFE,
            ($urandom_range(9, 0) < 7),
            $urandom() & 32'hFFFF_FFFC,
            {rand_parcel(), rand_parcel()},
            ($urandom_range(9, 0) < 6));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/c_fetch_buffer.md
Name: c_fetch_buffer

Overview:
- Halfword-parcel FIFO between the instruction cache response and the compressed-extension misalign/decode stage.
- Accepts 32-bit aligned fetch words and splits them into 16-bit parcels.
- Presents exactly one complete instruction per output beat: a 16-bit compressed one or a 32-bit one, including 32-bit instructions that straddle a word boundary.
- Absorbs icache/consumer rate mismatch and discards stale parcels on a taken branch.

Parameters:
- DEPTH, 8, parcel entries; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous active-high reset
- flush_i  input  1  taken branch/redirect; discard all buffered parcels
- flush_pc_i  input  32  redirect target; bit 1 selects first useful halfword
- in_valid_i  input  1  icache word valid
- in_ready_o  output  1  buffer can accept a word
- in_pc_i  input  32  address of word; bits[1:0] are always 0
- in_word_i  input  32  fetched word; bits[15:0] are the lower-address parcel
- out_valid_o  output  1  complete instruction at head
- out_ready_i  input  1  consumer takes instruction
- out_instr_o  output  32  {p1,p0} for 32-bit; {16'h0,p0} for compressed
- out_is_comp_o  output  1  head parcel bits[1:0] != 2'b11
- out_pc_o  output  32  address of head parcel

Behaviour:
- Storage:
  - DEPTH entries of {16-bit parcel, 32-bit pc}.
  - rd_ptr and wr_ptr are PTR_W wide and wrap modulo DEPTH.
  - count is PTR_W+1 wide, range 0..DEPTH.
- Reset (synchronous):
  - count=0, rd_ptr=wr_ptr=0, drop_low=0.
  - In the cycle after reset: out_valid_o=0, out_instr_o=0, out_is_comp_o=0, out_pc_o=0, in_ready_o=1.
- in_ready_o is combinational: (count <= DEPTH-2) && !flush_i.
- Push:
  - Occurs on in_valid_i && in_ready_o.
  - drop_low=0: write parcel {in_word_i[15:0], in_pc_i} then {in_word_i[31:16], in_pc_i+2}; wr_ptr += 2, count += 2.
  - drop_low=1: write only the upper parcel with pc in_pc_i+2; wr_ptr += 1, count += 1; clear drop_low.
- Output:
  - head p0 = entry[rd_ptr]; p1 = entry[rd_ptr+1 mod DEPTH].
  - comp = (p0[1:0] != 2'b11).
  - out_valid_o = (count>=1 && comp) || (count>=2 && !comp).
  - All out_* fields are combinational from the head entries and are forced to 0 when out_valid_o=0.
- Pop:
  - Occurs on out_valid_o && out_ready_i && !flush_i.
  - Advance rd_ptr and decrement count by 1 if comp, by 2 if not.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Both updates apply in the same cycle.
- 32-bit instruction with only its lower half buffered (count=1, !comp): out_valid_o=0 until the next word arrives. This is not an error.
- Flush:
  - In the cycle flush_i=1: rd_ptr=wr_ptr=0, count=0, drop_low=flush_pc_i[1].
  - Input and output handshakes in that cycle are ignored: in_ready_o=0, no pop.
  - Flush has priority over push, pop and drop_low clear.
  - Back-to-back flushes: the last one sets drop_low.
- Full: count>=DEPTH-1 deasserts in_ready_o. count never exceeds DEPTH; overflow is impossible by construction.
- Empty: count=0 gives out_valid_o=0. A pop is never taken while empty.
- Reset mid-transfer overrides flush and handshakes; the buffer is empty next cycle.
- Latency: a word pushed into an empty buffer is visible on the out_* ports in the following cycle. There is no combinational in-to-out bypass.

Decomposition:
- Shared c-ext defines package holds:
  - typedef type_parcel_s {logic [15:0] data; logic [31:0] pc;}
  - constant C_OPCODE_32 = 2'b11
  - PARCEL_W = 16
- No sub-module is needed. If a storage split is wanted, use one natural sub-module c_parcel_ram: a DEPTH x 48 register array with two write ports and two combinational read ports.

Test Plan:
- After reset, push word 0x00010001 at pc 0x100 → out_valid_o=1, is_comp=1, instr=0x00000001, pc=0x100; after pop → instr=0x00000001, pc=0x102; after second pop → out_valid_o=0.
- Push 0x00130513 at pc 0x200 → is_comp=0, instr=0x00130513, pc=0x200; one pop empties the buffer (count 0).
- Straddle: push 0x05130001 at pc 0x300 → compressed 0x0001 at pc 0x300, then count=1 and out_valid_o=0 (0x0513 is a 32-bit lower half). Push 0x00010013 at pc 0x304 → instr=0x00130513, pc=0x302.
- Flush with flush_pc_i=0x402, then push 0x00010513 at pc 0x400 → only parcel 0x0001 enters; out pc=0x402, is_comp=1; count=1.
- Hold out_ready_i=0 and push 4 words with DEPTH=8 → in_ready_o drops after the 4th push (count=8) and the 5th word is not accepted. Raise out_ready_i with a simultaneous push → count stays consistent and the pointers wrap correctly.
- Assert flush_i in the same cycle as in_valid_i and out_ready_i → no pop, word not stored, next-cycle out_valid_o=0 and in_ready_o=1.
